mem_port_arbiter: RTL and testbench

//  Shares the core's single unified memory port among the debug program loader,

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port among the debug program loader, the
//   instruction fetch frontend and the load/store unit. One transaction is
//   outstanding at a time. Priority is debug > data > fetch. A starvation
//   counter forces a fetch grant after STARVE_MAX consecutive data grants
//   made while fetch was waiting. A frontend flush kills the pending fetch
//   response.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   flush                    frontend redirect, kills in-flight fetch data
//   dbg_req/addr/wdata       debug loader word write
//   dbg_gnt, dbg_done        debug accepted / write acknowledged
//   if_req/addr              fetch read
//   if_gnt, if_rvalid/rdata  fetch accepted / fetch data
//   dm_req/we/be/addr/wdata  load/store request
//   dm_gnt, dm_rvalid/rdata  load/store accepted / load data or store ack
//   mem_req/we/be/addr/wdata memory request (one-cycle strobe)
//   mem_rvalid, mem_rdata    memory response, any latency >= 1
//   busy                     a transaction is outstanding
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | no transaction outstanding; arbitrate and grant this cycle
// S_WAIT | request issued; waiting for mem_rvalid from memory

module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,

    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DBG  = 2'd1,
        OWN_IF   = 2'd2,
        OWN_DM   = 2'd3
    } owner_t;

    state_t             state;
    state_t             state_nxt;
    owner_t             owner;
    owner_t             win;
    logic [CNT_W-1:0]   starve_cnt;
    logic               starve_full;
    logic               kill;

    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

    // Winner selection. Outputs are forced quiet while rst is held so that
    // the port shows all-zero during reset even with requests pending.
    always_comb begin
        win = OWN_NONE;
        if (state == S_IDLE && !rst) begin
            if (dbg_req)
                win = OWN_DBG;
            else if (if_req && starve_full)
                win = OWN_IF;
            else if (dm_req)
                win = OWN_DM;
            else if (if_req)
                win = OWN_IF;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_nxt = state;
        dbg_gnt   = 1'b0;
        dbg_done  = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        busy      = (state == S_WAIT);

        case (state)
            S_IDLE: begin
                case (win)
                    OWN_DBG: begin
                        dbg_gnt   = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_be    = 4'hF;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                    end
                    OWN_IF: begin
                        if_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_be    = 4'hF;
                        mem_addr  = if_addr;
                    end
                    OWN_DM: begin
                        dm_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = dm_we;
                        mem_be    = dm_be;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                    end
                    default: ;
                endcase
                if (win != OWN_NONE)
                    state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = S_IDLE;
                    case (owner)
                        OWN_DBG: dbg_done  = 1'b1;
                        OWN_DM:  dm_rvalid = 1'b1;
                        // A flush arriving together with the data still kills it.
                        OWN_IF:  if_rvalid = !kill && !flush;
                        default: ;
                    endcase
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign if_rdata = rst ? 32'h0 : mem_rdata;
    assign dm_rdata = rst ? 32'h0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            if (win != OWN_NONE)
                owner <= win;
        end
    end

    // Starvation counter: counts data grants taken while fetch was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || win == OWN_IF) begin
            starve_cnt <= '0;
        end else if (win == OWN_DM && !starve_full) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // kill marks the outstanding fetch response as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill <= 1'b0;
        end else if (state == S_WAIT && mem_rvalid) begin
            kill <= 1'b0;
        end else if (flush && (win == OWN_IF ||
                               (state == S_WAIT && owner == OWN_IF))) begin
            kill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    localparam logic [7:0] B_DBG_GNT  = 8'h80;
    localparam logic [7:0] B_DBG_DONE = 8'h40;
    localparam logic [7:0] B_IF_GNT   = 8'h20;
    localparam logic [7:0] B_IF_RV    = 8'h10;
    localparam logic [7:0] B_DM_GNT   = 8'h08;
    localparam logic [7:0] B_DM_RV    = 8'h04;
    localparam logic [7:0] B_MREQ     = 8'h02;
    localparam logic [7:0] B_BUSY     = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic        dbg_req;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_done;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    wire [7:0]  ctl = {dbg_gnt, dbg_done, if_gnt, if_rvalid,
                       dm_gnt, dm_rvalid, mem_req, busy};
    wire [68:0] mem_bundle = {mem_we, mem_be, mem_addr, mem_wdata};

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        flush = 0; dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        dbg_req = 1; if_req = 1; dm_req = 1; dm_we = 1; dm_be = 4'hF;
        dbg_addr = $urandom; if_addr = $urandom; dm_addr = $urandom;
        mem_rvalid = 1; mem_rdata = $urandom; flush = 0;
        #1;
        n_vec++;
        if (ctl !== 8'h00) begin
            n_miss++; $display("FAIL reset_ctl: got %h want 00", ctl);
        end
        n_vec++;
        if ({mem_bundle, if_rdata, dm_rdata} !== '0) begin
            n_miss++; $display("FAIL reset_data: got %h/%h/%h want 0", mem_bundle, if_rdata, dm_rdata);
        end
        tick();
        drive_idle();
        rst = 0;
        tick();
    endtask

    task automatic test_single_fetch();
        drive_idle(); if_req = 1; if_addr = 32'h100;
        #1;
        n_vec++;
        if (ctl !== (B_IF_GNT | B_MREQ) || mem_bundle !== {1'b0, 4'hF, 32'h100, 32'h0}) begin
            n_miss++; $display("FAIL fetch_grant: got %h %h want %h %h", ctl, mem_bundle, B_IF_GNT | B_MREQ, {1'b0, 4'hF, 32'h100, 32'h0});
        end
        tick(); if_req = 0; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL fetch_c1: got %h want %h", ctl, B_BUSY); end
        tick(); #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL fetch_c2: got %h want %h", ctl, B_BUSY); end
        tick(); mem_rvalid = 1; mem_rdata = 32'h00500093; #1;
        n_vec++;
        if (ctl !== (B_IF_RV | B_BUSY) || if_rdata !== 32'h00500093) begin
            n_miss++; $display("FAIL fetch_c3: got %h %h want %h 00500093", ctl, if_rdata, B_IF_RV | B_BUSY);
        end
        tick(); mem_rvalid = 0; #1;
        n_vec++;
        if (ctl !== 8'h00) begin n_miss++; $display("FAIL fetch_c4: got %h want 00", ctl); end
    endtask

    task automatic test_priority();
        drive_idle();
        dbg_req = 1; dbg_addr = 32'hD000_0010; dbg_wdata = 32'hCAFE_F00D;
        dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h0000_4000;
        if_req = 1; if_addr = 32'h0000_0200;
        #1;
        n_vec++;
        if (ctl !== (B_DBG_GNT | B_MREQ) || mem_bundle !== {1'b1, 4'hF, 32'hD000_0010, 32'hCAFE_F00D}) begin
            n_miss++; $display("FAIL prio_dbg: got %h %h", ctl, mem_bundle);
        end
        tick(); dbg_req = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== (B_DBG_DONE | B_BUSY)) begin n_miss++; $display("FAIL prio_dbg_done: got %h want %h", ctl, B_DBG_DONE | B_BUSY); end
        tick(); mem_rvalid = 0; #1;
        n_vec++;
        if (ctl !== (B_DM_GNT | B_MREQ) || mem_addr !== 32'h0000_4000 || mem_we !== 1'b0) begin
            n_miss++; $display("FAIL prio_dm: got %h %h want %h 00004000", ctl, mem_addr, B_DM_GNT | B_MREQ);
        end
        tick(); dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; #1;
        n_vec++;
        if (ctl !== (B_DM_RV | B_BUSY) || dm_rdata !== 32'h1234_5678) begin
            n_miss++; $display("FAIL prio_dm_rv: got %h %h want %h 12345678", ctl, dm_rdata, B_DM_RV | B_BUSY);
        end
        tick(); mem_rvalid = 0; #1;
        n_vec++;
        if (ctl !== (B_IF_GNT | B_MREQ) || mem_addr !== 32'h0000_0200) begin
            n_miss++; $display("FAIL prio_if: got %h %h want %h 00000200", ctl, mem_addr, B_IF_GNT | B_MREQ);
        end
        tick(); if_req = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== (B_IF_RV | B_BUSY)) begin n_miss++; $display("FAIL prio_if_rv: got %h want %h", ctl, B_IF_RV | B_BUSY); end
        tick(); mem_rvalid = 0;
    endtask

    task automatic test_starvation();
        logic [7:0] exp_g;
        logic [2:0] got_cnt;
        int exp_cnt;
        drive_idle(); tick();
        if_req = 1; if_addr = 32'h300; dm_req = 1; dm_addr = 32'h5000; dm_be = 4'hF;
        for (int k = 0; k < 7; k++) begin
            #1;
            exp_g = (k == 4) ? B_IF_GNT : B_DM_GNT;
            n_vec++;
            if (ctl !== (exp_g | B_MREQ)) begin
                n_miss++; $display("FAIL starve_grant[%0d]: got %h want %h", k, ctl, exp_g | B_MREQ);
            end
            tick(); mem_rvalid = 1; #1;
            got_cnt = dut.starve_cnt;
            exp_cnt = (k < 4) ? k + 1 : k - 4;
            n_vec++;
            if (got_cnt !== 3'(exp_cnt)) begin
                n_miss++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", k, got_cnt, exp_cnt);
            end
            n_vec++;
            if (ctl !== (((k == 4) ? B_IF_RV : B_DM_RV) | B_BUSY)) begin
                n_miss++; $display("FAIL starve_rv[%0d]: got %h", k, ctl);
            end
            tick(); mem_rvalid = 0;
        end
        drive_idle(); tick();
    endtask

    task automatic test_flush();
        // flush one cycle after grant, latency 2
        drive_idle(); if_req = 1; if_addr = 32'h400; #1;
        n_vec++;
        if (ctl !== (B_IF_GNT | B_MREQ)) begin n_miss++; $display("FAIL flush_grant: got %h", ctl); end
        tick(); if_req = 0; flush = 1; dm_req = 1; dm_addr = 32'h6000; dm_be = 4'hF; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL flush_c1: got %h want %h", ctl, B_BUSY); end
        tick(); flush = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL flush_suppress: got %h want %h", ctl, B_BUSY); end
        tick(); mem_rvalid = 0; #1;
        n_vec++;
        if (ctl !== (B_DM_GNT | B_MREQ)) begin n_miss++; $display("FAIL flush_next_grant: got %h want %h", ctl, B_DM_GNT | B_MREQ); end
        tick(); dm_req = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== (B_DM_RV | B_BUSY)) begin n_miss++; $display("FAIL flush_dm_rv: got %h", ctl); end
        // flush in the grant cycle
        tick(); drive_idle(); if_req = 1; flush = 1; #1;
        n_vec++;
        if (ctl !== (B_IF_GNT | B_MREQ)) begin n_miss++; $display("FAIL flush_at_grant: got %h", ctl); end
        tick(); if_req = 0; flush = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL flush_at_grant_rv: got %h want %h", ctl, B_BUSY); end
        // flush together with the response
        tick(); mem_rvalid = 0; if_req = 1; #1;
        tick(); if_req = 0; mem_rvalid = 1; flush = 1; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL flush_with_rv: got %h want %h", ctl, B_BUSY); end
        // kill must have cleared: a clean fetch delivers data
        tick(); drive_idle(); if_req = 1; #1;
        tick(); if_req = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== (B_IF_RV | B_BUSY)) begin n_miss++; $display("FAIL flush_kill_clear: got %h want %h", ctl, B_IF_RV | B_BUSY); end
        tick(); drive_idle();
    endtask

    task automatic test_byte_store();
        drive_idle();
        dm_req = 1; dm_we = 1; dm_be = 4'b0100; dm_addr = 32'h2002; dm_wdata = 32'h00AB0000;
        #1;
        n_vec++;
        if (ctl !== (B_DM_GNT | B_MREQ) || mem_bundle !== {1'b1, 4'b0100, 32'h2002, 32'h00AB0000}) begin
            n_miss++; $display("FAIL store_mem: got %h %h", ctl, mem_bundle);
        end
        tick(); dm_req = 0; mem_rvalid = 1; #1;
        n_vec++;
        if (ctl !== (B_DM_RV | B_BUSY)) begin n_miss++; $display("FAIL store_ack: got %h want %h", ctl, B_DM_RV | B_BUSY); end
        tick(); drive_idle();
    endtask

    task automatic test_reset_mid_wait();
        drive_idle(); if_req = 1; if_addr = 32'h500; #1;
        tick(); if_req = 0; #1;
        n_vec++;
        if (ctl !== B_BUSY) begin n_miss++; $display("FAIL rstw_busy: got %h want %h", ctl, B_BUSY); end
        rst = 1; #1;
        n_vec++;
        if (ctl !== 8'h00 || mem_bundle !== '0) begin n_miss++; $display("FAIL rstw_outputs: got %h %h want 0", ctl, mem_bundle); end
        tick(); rst = 0; #1;
        n_vec++;
        if (ctl !== 8'h00) begin n_miss++; $display("FAIL rstw_release: got %h want 00", ctl); end
        tick(); mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; #1;
        n_vec++;
        if (ctl !== 8'h00) begin n_miss++; $display("FAIL rstw_late_rv: got %h want 00", ctl); end
        tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h600; #1;
        n_vec++;
        if (ctl !== (B_IF_GNT | B_MREQ) || mem_addr !== 32'h600) begin
            n_miss++; $display("FAIL rstw_regrant: got %h %h want %h 00000600", ctl, mem_addr, B_IF_GNT | B_MREQ);
        end
        tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_CAFE; #1;
        n_vec++;
        if (ctl !== (B_IF_RV | B_BUSY) || if_rdata !== 32'h0BAD_CAFE) begin
            n_miss++; $display("FAIL rstw_rv: got %h %h", ctl, if_rdata);
        end
        tick(); drive_idle();
    endtask

    // Transaction-level reference: who owns the port, how many data grants
    // fetch has watched go by, and whether the pending fetch was flushed.
    task automatic test_random();
        bit         m_busy = 0, m_kill = 0;
        int         m_owner = 0, m_starve = 0, m_win, last_win = 0, resp_cycle = -1;
        logic [7:0] exp_ctl;
        logic [68:0] exp_mem;
        drive_idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (last_win == 1) dbg_req = 0;
            if (last_win == 2) if_req = 0;
            if (last_win == 3) dm_req = 0;
            if (!dbg_req && $urandom_range(9) == 0) begin
                dbg_req = 1; dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            if (!if_req && $urandom_range(1) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom); dm_be = 4'($urandom);
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            flush = ($urandom_range(7) == 0);
            mem_rdata = $urandom;
            if (m_busy) mem_rvalid = (cyc == resp_cycle);
            else        mem_rvalid = ($urandom_range(15) == 0);
            #1;

            m_win = 0;
            if (!m_busy) begin
                if (dbg_req)                            m_win = 1;
                else if (if_req && m_starve == STARVE_MAX) m_win = 2;
                else if (dm_req)                        m_win = 3;
                else if (if_req)                        m_win = 2;
            end
            exp_ctl = m_busy ? B_BUSY : 8'h00;
            exp_mem = '0;
            case (m_win)
                1: begin exp_ctl |= B_DBG_GNT | B_MREQ; exp_mem = {1'b1, 4'hF, dbg_addr, dbg_wdata}; end
                2: begin exp_ctl |= B_IF_GNT | B_MREQ;  exp_mem = {1'b0, 4'hF, if_addr, 32'h0}; end
                3: begin exp_ctl |= B_DM_GNT | B_MREQ;  exp_mem = {dm_we, dm_be, dm_addr, dm_wdata}; end
                default: ;
            endcase
            if (m_busy && mem_rvalid) begin
                if (m_owner == 1) exp_ctl |= B_DBG_DONE;
                if (m_owner == 3) exp_ctl |= B_DM_RV;
                if (m_owner == 2 && !m_kill && !flush) exp_ctl |= B_IF_RV;
            end
            n_vec++;
            if (ctl !== exp_ctl) begin
                n_miss++; $display("FAIL rand_ctl[%0d]: got %h want %h", cyc, ctl, exp_ctl);
            end
            if (m_win != 0) begin
                n_vec++;
                if (mem_bundle !== exp_mem) begin
                    n_miss++; $display("FAIL rand_mem[%0d]: got %h want %h", cyc, mem_bundle, exp_mem);
                end
            end
            if ((exp_ctl & (B_IF_RV | B_DM_RV)) != 0) begin
                n_vec++;
                if (((exp_ctl & B_IF_RV) != 0 && if_rdata !== mem_rdata) ||
                    ((exp_ctl & B_DM_RV) != 0 && dm_rdata !== mem_rdata)) begin
                    n_miss++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h", cyc, if_rdata, dm_rdata, mem_rdata);
                end
            end

            if (!if_req)                            m_starve = 0;
            else if (m_win == 2)                    m_starve = 0;
            else if (m_win == 3 && m_starve < STARVE_MAX) m_starve++;
            if (m_win != 0) begin
                m_busy = 1; m_owner = m_win; m_kill = (m_win == 2) && flush;
                resp_cycle = cyc + int'($urandom_range(3, 1));
            end else if (m_busy) begin
                if (mem_rvalid) begin m_busy = 0; m_kill = 0; end
                else if (m_owner == 2 && flush) m_kill = 1;
            end
            last_win = m_win;
            tick();
        end
        drive_idle(); tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_flush();
        test_byte_store();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
